// File: rtl/dm_responder.sv
// dm_responder: stage-M data-memory responder with a fixed response latency and byte-enabled stores.
// Optional store trace: define DM_STORE_LOG_EN.
module dm_responder #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = '0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [3:0]  req_be_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [31:0] req_pc_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e              state_q;
    logic [3:0]          cnt_q;
    logic                req_ready_q, rsp_valid_q, rsp_err_q, we_q;
    logic [31:0]         rsp_rdata_q, addr_q, wdata_q;
    logic [3:0]          be_q;
    logic [31:0]         mem_q [DEPTH];
    logic [DEPTH-1:0]    vld_q;
    logic                is_idle, commit, c_we, c_err, wr;
    logic [3:0]          c_be;
    logic [31:0]         c_addr, c_wdata, c_off, cur, merged, rdata;
    logic [ADDR_W-1:0]   c_idx;

    // With LATENCY=0 the commit happens on the acceptance edge, so decode straight from the request.
    assign is_idle = state_q == IDLE;
    assign c_addr  = is_idle ? req_addr_i  : addr_q;
    assign c_we    = is_idle ? req_we_i    : we_q;
    assign c_be    = is_idle ? req_be_i    : be_q;
    assign c_wdata = is_idle ? req_wdata_i : wdata_q;
    assign c_off   = c_addr - BASE_ADDR;
    assign c_idx   = c_off[ADDR_W+1:2];
    assign c_err   = (c_addr[1:0] != 2'b00) || ((c_off >> (ADDR_W + 2)) != '0);
    assign commit  = is_idle ? (req_valid_i && LATENCY == 0) : (state_q == WAIT && cnt_q == 4'd0);
    assign wr      = commit && c_we && !c_err;
    assign cur     = vld_q[c_idx] ? mem_q[c_idx] : '0;
    assign rdata   = (c_we || c_err) ? '0 : cur;

    always_comb begin
        merged = cur;
        for (int i = 0; i < 4; i++)
            if (c_be[i]) merged[8*i +: 8] = c_wdata[8*i +: 8];
    end

`ifdef DM_STORE_LOG_EN
    logic [31:0] pc_q, c_pc;
    assign c_pc = is_idle ? req_pc_i : pc_q;
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) pc_q <= '0;
        else if (is_idle && req_valid_i) pc_q <= req_pc_i;
    always_ff @(posedge clk_i)
        if (rst_ni && wr && c_be != 4'b0000)
            $display("%d@%h: *%h <= %h", $time, c_pc, {c_addr[31:2], 2'b00}, merged);
`else
    logic unused_pc;
    assign unused_pc = ^req_pc_i;
`endif

    // Reset clears the array logically through per-word valid bits.
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) vld_q <= '0;
        else if (wr) vld_q[c_idx] <= 1'b1;

    always_ff @(posedge clk_i)
        if (wr) mem_q[c_idx] <= merged;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
        end else begin
            case (state_q)
                IDLE: if (req_valid_i) begin
                    addr_q      <= req_addr_i;
                    wdata_q     <= req_wdata_i;
                    we_q        <= req_we_i;
                    be_q        <= req_be_i;
                    req_ready_q <= 1'b0;
                    cnt_q       <= 4'(LATENCY - 1);
                    state_q     <= LATENCY == 0 ? RESP : WAIT;
                end
                WAIT: if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
                      else state_q <= RESP;
                RESP: if (rsp_ready_i) begin
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (commit) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= rdata;
                rsp_err_q   <= c_err;
            end
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: directed vector bench for dm_responder, LATENCY=2 and LATENCY=0 instances.
module tb_dm_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid [2], req_ready [2], req_we [2], rsp_valid [2], rsp_ready [2], rsp_err [2];
    logic [3:0]  req_be    [2];
    logic [31:0] req_addr  [2], req_wdata [2], req_pc [2], rsp_rdata [2];

    dm_responder #(.ADDR_W(10), .LATENCY(2), .BASE_ADDR(32'h0)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we[0]),
        .req_be_i(req_be[0]), .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]), .req_pc_i(req_pc[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]), .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0])
    );

    dm_responder #(.ADDR_W(10), .LATENCY(0), .BASE_ADDR(32'h0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we[1]),
        .req_be_i(req_be[1]), .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]), .req_pc_i(req_pc[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]), .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1])
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_rsp(input int d, output int n);
        n = 0;
        @(negedge clk);
        while (!rsp_valid[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_req(input int d, input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err,
                          input string tag);
        int n;
        @(negedge clk);
        req_valid[d] = 1'b1; req_we[d] = we; req_be[d] = be;
        req_addr[d] = addr; req_wdata[d] = wdata; req_pc[d] = 32'h3000;
        check({tag, " req_ready idle"}, 32'(req_ready[d]), 32'd1);
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
        wait_rsp(d, n);
        check({tag, " latency"}, 32'(n), d == 0 ? 32'd2 : 32'd0);
        check({tag, " rdata"}, rsp_rdata[d], exp_rd);
        check({tag, " err"}, 32'(rsp_err[d]), 32'(exp_err));
        check({tag, " req_ready busy"}, 32'(req_ready[d]), 32'd0);
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[d] = 1'b0;
        @(negedge clk);
        check({tag, " rsp_valid drop"}, 32'(rsp_valid[d]), 32'd0);
        check({tag, " req_ready back"}, 32'(req_ready[d]), 32'd1);
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    vec_t v [15];
    int   n;

    initial begin
        v[0]  = '{1'b1, 4'hF,    32'h0000_0010, 32'hDEAD_BEEF, 32'h0,          1'b0};
        v[1]  = '{1'b0, 4'h0,    32'h0000_0010, 32'h0,         32'hDEAD_BEEF,  1'b0};
        v[2]  = '{1'b1, 4'b0010, 32'h0000_0010, 32'h0000_5500, 32'h0,          1'b0};
        v[3]  = '{1'b0, 4'h0,    32'h0000_0010, 32'h0,         32'hDEAD_55EF,  1'b0};
        v[4]  = '{1'b0, 4'hF,    32'h0000_0013, 32'h0,         32'h0,          1'b1};
        v[5]  = '{1'b1, 4'hF,    32'h0000_0000, 32'hA5A5_A5A5, 32'h0,          1'b0};
        v[6]  = '{1'b1, 4'hF,    32'h0000_1000, 32'hFFFF_FFFF, 32'h0,          1'b1};
        v[7]  = '{1'b0, 4'h0,    32'h0000_0000, 32'h0,         32'hA5A5_A5A5,  1'b0};
        v[8]  = '{1'b1, 4'h0,    32'h0000_0014, 32'h1234_5678, 32'h0,          1'b0};
        v[9]  = '{1'b0, 4'h0,    32'h0000_0014, 32'h0,         32'h0,          1'b0};
        v[10] = '{1'b1, 4'b1001, 32'h0000_0FFC, 32'h1122_3344, 32'h0,          1'b0};
        v[11] = '{1'b0, 4'h0,    32'h0000_0FFC, 32'h0,         32'h1100_0044,  1'b0};
        v[12] = '{1'b0, 4'h0,    32'hFFFF_FFFC, 32'h0,         32'h0,          1'b1};
        v[13] = '{1'b1, 4'b0100, 32'h0000_0018, 32'hAABB_CCDD, 32'h0,          1'b0};
        v[14] = '{1'b0, 4'h1,    32'h0000_0018, 32'h0,         32'h00BB_0000,  1'b0};

        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_be[d] = '0; req_addr[d] = '0;
            req_wdata[d] = '0; req_pc[d] = '0; rsp_ready[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset req_ready", 32'(req_ready[0]), 32'd1);
        check("reset rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("reset rsp_rdata", rsp_rdata[0], 32'd0);
        check("reset rsp_err", 32'(rsp_err[0]), 32'd0);

        for (int i = 0; i < 15; i++)
            do_req(0, v[i].we, v[i].be, v[i].addr, v[i].wdata, v[i].rd, v[i].err, $sformatf("vec%0d", i));

        // Backpressure, with a competing store held on the request port that must be ignored.
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h10;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        wait_rsp(0, n);
        check("bp latency", 32'(n), 32'd2);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_be[0] = 4'hF; req_wdata[0] = 32'h0;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp%0d rsp_valid", c), 32'(rsp_valid[0]), 32'd1);
            check($sformatf("bp%0d rdata", c), rsp_rdata[0], 32'hDEAD_55EF);
            check($sformatf("bp%0d err", c), 32'(rsp_err[0]), 32'd0);
            check($sformatf("bp%0d req_ready", c), 32'(req_ready[0]), 32'd0);
            @(negedge clk);
        end
        req_valid[0] = 1'b0; rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[0] = 1'b0;
        @(negedge clk);
        check("bp rsp_valid drop", 32'(rsp_valid[0]), 32'd0);
        check("bp req_ready back", 32'(req_ready[0]), 32'd1);
        do_req(0, 1'b0, 4'h0, 32'h10, 32'h0, 32'hDEAD_55EF, 1'b0, "bp reload");

        // Reset while a store sits in WAIT.
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_be[0] = 4'hF;
        req_addr[0] = 32'h20; req_wdata[0] = 32'h1234_5678;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        check("midwait req_ready pre", 32'(req_ready[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midwait req_ready", 32'(req_ready[0]), 32'd1);
        check("midwait rsp_valid", 32'(rsp_valid[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("midwait no late rsp", 32'(rsp_valid[0]), 32'd0);
        do_req(0, 1'b0, 4'h0, 32'h20, 32'h0, 32'h0, 1'b0, "midwait load 0x20");
        do_req(0, 1'b0, 4'h0, 32'h10, 32'h0, 32'h0, 1'b0, "post-reset load 0x10");

        // Zero-latency instance.
        do_req(1, 1'b1, 4'hF, 32'h10, 32'hCAFE_F00D, 32'h0, 1'b0, "lat0 store");
        do_req(1, 1'b0, 4'h0, 32'h10, 32'h0, 32'hCAFE_F00D, 1'b0, "lat0 load");
        do_req(1, 1'b0, 4'h0, 32'h11, 32'h0, 32'h0, 1'b1, "lat0 misaligned");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
